// File: rtl/branch_predict_unit_pkg.sv
// Shared types and constants for the branch predictor.
// Counter encoding, FSM states and the saturating counter step.
package bp_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] STEP = 32'd4;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    IDLE,
    RECOVER
  } bp_state_t;

  function automatic logic [1:0] sat_cnt(
    input logic [1:0] c,
    input logic       up
  );
    if (up) return (c == ST) ? ST : c + 2'd1;
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction
endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline-side bundle of the branch predictor: fetch lookup,
// EX resolution and recovery/flush controls.
interface branch_predict_unit_if #(
  parameter int CNT_W = 16
);
  import bp_pkg::*;

  logic            stall;
  logic [PC_W-1:0] if_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            ex_branch;
  logic [PC_W-1:0] ex_pc;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pred_target;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            flush_ifid;
  logic            flush_idex;
  logic            flush_exmem;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output stall, if_pc, ex_branch, ex_pc, ex_taken,
    output ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc,
    input  flush_ifid, flush_idex, flush_exmem,
    input  mispredict_count
  );

  modport slave (
    input  stall, if_pc, ex_branch, ex_pc, ex_taken,
    input  ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc,
    output flush_ifid, flush_idex, flush_exmem,
    output mispredict_count
  );
endinterface

// File: rtl/branch_predict_unit_table.sv
// Direct-mapped counter/target table: async read port,
// synchronous write port with saturating counter update.
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] i_rd_pc,
  output logic        o_rd_taken,
  output logic [31:0] o_rd_target,
  input  logic        i_wr_en,
  input  logic [31:2] i_wr_pc,
  input  logic        i_wr_taken,
  input  logic [31:0] i_wr_target
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX - 2;

  logic [1:0]       r_cnt    [ENTRIES];
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];

  logic [IDX-1:0] w_ri;
  logic [IDX-1:0] w_wi;
  logic           w_hit;

  assign w_ri = i_rd_pc[IDX+1:2];
  assign w_wi = i_wr_pc[IDX+1:2];

  assign w_hit = r_valid[w_ri] &&
                 (r_tag[w_ri] == i_rd_pc[31:IDX+2]);
  assign o_rd_taken  = w_hit & r_cnt[w_ri][1];
  assign o_rd_target = r_target[w_ri];

  // Counter moves even on a tag miss; aliases share history.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i]    <= WNT;
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_cnt[w_wi] <= sat_cnt(r_cnt[w_wi], i_wr_taken);
      if (i_wr_taken) begin
        r_valid[w_wi]  <= 1'b1;
        r_tag[w_wi]    <= i_wr_pc[31:IDX+2];
        r_target[w_wi] <= i_wr_target;
      end
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor top: fetch prediction, EX-stage mispredict
// detection, one-cycle redirect/flush FSM and statistics.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic reset,
  branch_predict_unit_if.slave bus
);
  bp_state_t r_state;
  bp_state_t w_next;

  logic [PC_W-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_count;

  logic            w_resolve;
  logic            w_mis;
  logic            w_rd_taken;
  logic [PC_W-1:0] w_rd_target;

  bp_table #(.ENTRIES(ENTRIES)) u_table (
    .clk        (clk),
    .reset      (reset),
    .i_rd_pc    (bus.if_pc[31:2]),
    .o_rd_taken (w_rd_taken),
    .o_rd_target(w_rd_target),
    .i_wr_en    (w_resolve),
    .i_wr_pc    (bus.ex_pc[31:2]),
    .i_wr_taken (bus.ex_taken),
    .i_wr_target(bus.ex_target)
  );

  assign bus.pred_taken  = w_rd_taken;
  assign bus.pred_target = w_rd_taken ? w_rd_target
                                      : bus.if_pc + STEP;

  assign w_resolve = bus.ex_branch & ~bus.stall &
                     (r_state == IDLE);
  assign w_mis = (bus.ex_taken != bus.ex_pred_taken) |
                 (bus.ex_taken & bus.ex_pred_taken &
                  (bus.ex_target != bus.ex_pred_target));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_resolve && w_mis) w_next = RECOVER;
      RECOVER: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect_pc <= '0;
      r_count       <= '0;
    end else if (w_resolve && w_mis) begin
      r_redirect_pc <= bus.ex_taken ? bus.ex_target
                                    : bus.ex_pc + STEP;
      if (r_count != '1) r_count <= r_count + CNT_W'(1);
    end
  end

  assign bus.redirect         = (r_state == RECOVER);
  assign bus.flush_ifid       = (r_state == RECOVER);
  assign bus.flush_idex       = (r_state == RECOVER);
  assign bus.flush_exmem      = (r_state == RECOVER);
  assign bus.redirect_pc      = r_redirect_pc;
  assign bus.mispredict_count = r_count;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios plus random
// traffic against a behavioural predictor model.
module tb_branch_predict_unit;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 16;
  localparam int IDX     = $clog2(ENTRIES);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.CNT_W(CNT_W)) u_if ();

  branch_predict_unit #(
    .ENTRIES(ENTRIES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  int total = 0;
  int bad   = 0;

  int          m_cnt [ENTRIES];
  bit          m_val [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  bit          m_rec;
  logic [31:0] m_rpc;
  longint      m_count;
  bit          m_known = 1'b0;

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic void mpred(input logic [31:0] pc,
                                output bit pt,
                                output logic [31:0] ptg);
    int  i;
    bit  hit;
    i   = ix(pc);
    hit = m_val[i] && (m_tag[i] == (pc >> (IDX + 2)));
    pt  = hit && (m_cnt[i] >= 2);
    ptg = pt ? m_tgt[i] : pc + 32'd4;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic chk();
    bit          pt;
    logic [31:0] ptg;
    if (!m_known) return;
    mpred(u_if.if_pc, pt, ptg);
    cmp("pred_taken", 32'(u_if.pred_taken), 32'(pt));
    cmp("pred_target", u_if.pred_target, ptg);
    cmp("redirect", 32'(u_if.redirect), 32'(m_rec));
    cmp("flush_ifid", 32'(u_if.flush_ifid), 32'(m_rec));
    cmp("flush_idex", 32'(u_if.flush_idex), 32'(m_rec));
    cmp("flush_exmem", 32'(u_if.flush_exmem), 32'(m_rec));
    cmp("redirect_pc", u_if.redirect_pc, m_rpc);
    cmp("mispredict_count", 32'(u_if.mispredict_count),
        32'(m_count));
  endtask

  task automatic upd();
    bit res, mis;
    int i;
    if (reset) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_cnt[k] = 1;
        m_val[k] = 1'b0;
        m_tag[k] = '0;
        m_tgt[k] = '0;
      end
      m_rec   = 1'b0;
      m_rpc   = '0;
      m_count = 0;
      m_known = 1'b1;
      return;
    end
    if (!m_known) return;
    res = u_if.ex_branch && !u_if.stall && !m_rec;
    mis = (u_if.ex_taken != u_if.ex_pred_taken) ||
          (u_if.ex_taken && u_if.ex_pred_taken &&
           u_if.ex_target != u_if.ex_pred_target);
    if (res) begin
      i = ix(u_if.ex_pc);
      if (u_if.ex_taken) begin
        m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
        m_val[i] = 1'b1;
        m_tag[i] = u_if.ex_pc >> (IDX + 2);
        m_tgt[i] = u_if.ex_target;
      end else begin
        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
      end
    end
    if (res && mis) begin
      m_rpc = u_if.ex_taken ? u_if.ex_target
                            : u_if.ex_pc + 32'd4;
      if (m_count < (64'd1 << CNT_W) - 1) m_count++;
    end
    m_rec = res && mis;
  endtask

  task automatic tick();
    @(posedge clk);
    upd();
    #1;
  endtask

  task automatic drv(input bit rs, input bit st, input bit br,
                     input logic [31:0] pc, input bit tk,
                     input logic [31:0] tg, input bit pt,
                     input logic [31:0] ptg,
                     input logic [31:0] ifpc);
    reset               = rs;
    u_if.stall          = st;
    u_if.ex_branch      = br;
    u_if.ex_pc          = pc;
    u_if.ex_taken       = tk;
    u_if.ex_target      = tg;
    u_if.ex_pred_taken  = pt;
    u_if.ex_pred_target = ptg;
    u_if.if_pc          = ifpc;
    #1;
    chk();
  endtask

  task automatic idle(input logic [31:0] ifpc);
    drv(0, 0, 0, 0, 0, 0, 0, 0, ifpc);
  endtask

  function automatic logic [31:0] rpc_pool();
    return 32'h1000 | (32'($urandom_range(0, 3)) << 10) |
           (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0, 32'h40);
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 32'h40);
    tick();
    idle(32'h40);
    cmp("rst_pred_taken", 32'(u_if.pred_taken), 32'd0);
    cmp("rst_pred_target", u_if.pred_target, 32'h44);
    cmp("rst_redirect", 32'(u_if.redirect), 32'd0);
    cmp("rst_count", 32'(u_if.mispredict_count), 32'd0);

    drv(0, 0, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0);
    tick();
    idle(32'h0);
    cmp("cold_redirect", 32'(u_if.redirect), 32'd1);
    cmp("cold_rpc", u_if.redirect_pc, 32'h200);
    cmp("cold_flush_ifid", 32'(u_if.flush_ifid), 32'd1);
    cmp("cold_flush_idex", 32'(u_if.flush_idex), 32'd1);
    cmp("cold_flush_exmem", 32'(u_if.flush_exmem), 32'd1);
    cmp("cold_count", 32'(u_if.mispredict_count), 32'd1);
    tick();
    idle(32'h100);
    cmp("cold_done_redirect", 32'(u_if.redirect), 32'd0);
    cmp("cold_done_flush", 32'(u_if.flush_exmem), 32'd0);
    cmp("cold_hit_taken", 32'(u_if.pred_taken), 32'd1);
    cmp("cold_hit_target", u_if.pred_target, 32'h200);

    for (int n = 0; n < 4; n++) begin
      drv(0, 0, 1, 32'h100, 0, 32'h200, 0, 0, 32'h100);
      if (n > 0)
        cmp("sat_pred_taken", 32'(u_if.pred_taken), 32'd0);
      cmp("sat_redirect", 32'(u_if.redirect), 32'd0);
      tick();
    end
    idle(32'h100);
    cmp("sat_final_taken", 32'(u_if.pred_taken), 32'd0);
    cmp("sat_final_target", u_if.pred_target, 32'h104);
    cmp("sat_count", 32'(u_if.mispredict_count), 32'd1);

    drv(0, 0, 1, 32'h100, 1, 32'h200, 1, 32'h300, 32'h0);
    tick();
    idle(32'h0);
    cmp("tgt_rpc", u_if.redirect_pc, 32'h200);
    cmp("tgt_count", 32'(u_if.mispredict_count), 32'd2);
    tick();

    drv(0, 0, 1, 32'h188, 1, 32'h400, 0, 0, 32'h0);
    tick();
    drv(0, 0, 1, 32'h18c, 0, 32'h0, 1, 32'h800, 32'h18c);
    cmp("wp_redirect", 32'(u_if.redirect), 32'd1);
    cmp("wp_rpc", u_if.redirect_pc, 32'h400);
    tick();
    idle(32'h18c);
    cmp("wp_no_second", 32'(u_if.redirect), 32'd0);
    cmp("wp_count", 32'(u_if.mispredict_count), 32'd3);

    drv(0, 1, 1, 32'h1a0, 1, 32'h600, 0, 0, 32'h1a0);
    tick();
    idle(32'h1a0);
    cmp("stall_redirect", 32'(u_if.redirect), 32'd0);
    cmp("stall_count", 32'(u_if.mispredict_count), 32'd3);
    cmp("stall_no_upd", 32'(u_if.pred_taken), 32'd0);

    drv(0, 0, 1, 32'h1b0, 1, 32'h700, 0, 0, 32'h0);
    tick();
    drv(1, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    cmp("rr_in_recover", 32'(u_if.redirect), 32'd1);
    tick();
    idle(32'h0);
    cmp("rr_redirect", 32'(u_if.redirect), 32'd0);
    cmp("rr_flush", 32'(u_if.flush_ifid), 32'd0);
    cmp("rr_count", 32'(u_if.mispredict_count), 32'd0);

    drv(0, 0, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0);
    tick();
    drv(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    tick();
    drv(0, 0, 1, 32'h140, 1, 32'h500, 0, 0, 32'h140);
    cmp("rbw_old_entry", u_if.pred_target, 32'h144);
    tick();
    idle(32'h0);
    tick();
    idle(32'h100);
    cmp("alias_miss", u_if.pred_target, 32'h104);
    idle(32'h140);
    cmp("alias_hit", u_if.pred_target, 32'h500);
    tick();

    for (int n = 0; n < 3000; n++) begin
      bit          rs, st, br, tk, pt;
      logic [31:0] pc, tg, ptg, ifpc;
      rs = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 99) < 20);
      br = ($urandom_range(0, 99) < 60);
      pc = rpc_pool();
      tk = 1'($urandom_range(0, 1));
      tg = 32'($urandom_range(0, 7)) << 6;
      if ($urandom_range(0, 1) == 1) begin
        mpred(pc, pt, ptg);
        if (tk && pt && $urandom_range(0, 3) != 0) ptg = tg;
      end else begin
        pt  = 1'($urandom_range(0, 1));
        ptg = 32'($urandom_range(0, 7)) << 6;
      end
      ifpc = ($urandom_range(0, 9) < 3) ? pc : rpc_pool();
      drv(rs, st, br, pc, tk, tg, pt, ptg, ifpc);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
